tlc_param: RTL
==============

// Module: tlc_param
// PURPOSE
//  Parametrised two-road traffic light controller, the successor to the fixed-timing TLC.
//  Phase durations are configurable, and per-road demand requests can end the opposing green early.
//  Adds an enable/hold input and an emergency flashing-yellow mode.
//  Drives the North_South/East_West lamp buses and publishes the current phase for monitors.
// PARAMETERS
//  CNT_W       8   phase counter width; must satisfy 2**CNT_W > max duration
//  GREEN_NS    15  NS green duration, cycles (>=1)
//  GREEN_EW    15  EW green duration, cycles (>=1)
//  YELLOW      3   yellow duration, both roads, cycles (>=1)
//  ALL_RED     3   all-red clearance duration, cycles (>=1)
//  MIN_GREEN   5   minimum green before a demand request may end it (1..min(GREEN_NS,GREEN_EW))
//  FLASH_HALF  2   flash half-period, cycles (>=1)
// PORTS
//  clock        in   1  system clock, rising edge
//  reset_n      in   1  asynchronous active-low reset
//  enable       in   1  1 = run; 0 = freeze phase and counter
//  flash_mode   in   1  1 = emergency flashing yellow
//  req_ns       in   1  demand to serve NS; single-cycle pulse or level
//  req_ew       in   1  demand to serve EW; single-cycle pulse or level
//  North_South  out  4  lamp code: red=4'd1, green=4'd2, yellow=4'd4, off=4'd0
//  East_West    out  4  lamp code, same encoding
//  phase        out  3  0 NS_G, 1 NS_Y, 2 RED_A, 3 EW_G, 4 EW_Y, 5 RED_B, 6 FLASH
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - phase=RED_B, cnt=0, pend_ns=pend_ew=0, flash toggle=0.
//   - North_South=East_West=red.
//  Registers and lamps:
//   - All outputs are registered; lamps change on the same edge as phase.
//   - cnt is an up-counter and clears to 0 on every phase change.
//  Phase order and lamps (NS/EW):
//   NS_G(G/R) -> NS_Y(Y/R) -> RED_A(R/R) -> EW_G(R/G) -> EW_Y(R/Y) -> RED_B(R/R) -> NS_G.
//  Phase exit:
//   - A phase of duration D exits on the edge where cnt==D-1, so it occupies exactly D cycles.
//  Demand latching:
//   - pend_ew sets on req_ew while phase!=EW_G; pend_ns sets on req_ns while phase!=NS_G.
//   - The pending bit clears on entry to the served green.
//   - A request arriving during its own green is ignored.
//  Early exit:
//   - NS_G exits early when (pend_ew|req_ew) && cnt>=MIN_GREEN-1. EW_G mirrors this with the NS demand.
//   - Yellow and all-red phases are never shortened.
//  enable=0:
//   - phase, cnt and lamps hold.
//   - Demand requests are still latched.
//  flash_mode=1 (priority over enable):
//   - The next edge enters FLASH, cnt=0.
//   - Both lamps show yellow for FLASH_HALF cycles, then off for FLASH_HALF cycles, repeating.
//   - Each toggle occurs on the edge where cnt==FLASH_HALF-1.
//  Flash exit:
//   - flash_mode=0 while in FLASH: the next edge enters RED_B, cnt=0, lamps R/R.
//   - Normal sequencing resumes from RED_B to NS_G.
//   - Pending demands survive flash.
//  Invariants:
//   - Never green+green, green+yellow or yellow+yellow outside FLASH.
//   - Every green is preceded by at least ALL_RED cycles of red/red.
//   - Illegal phase code (7) recovers to RED_B on the next edge.
//  Reset mid-operation:
//   - Immediately forces red/red and RED_B.
//   - Pending demands are discarded.
// TESTING (defaults)
//  1 Release reset, enable=1 -> R/R 3 cyc, NS G 15, NS Y 3, R/R 3, EW G 15, EW Y 3, R/R 3; period 42 cyc.
//  2 req_ew pulse in NS_G cnt=0 -> NS_G lasts exactly 5 cyc, then NS Y 3, R/R 3; pend_ew clears on EW_G.
//  3 req_ew pulse in NS_G cnt=9 -> NS_G exits that edge (10 cyc total); req_ns during NS_G ignored.
//  4 enable=0 for 10 cyc at NS_Y cnt=1 -> lamps/phase/cnt frozen; after release NS_Y lasts 2 more cyc.
//  5 flash_mode=1 during EW_G -> next edge phase=6, both yellow 2 cyc, off 2 cyc, repeating;
//    drop flash_mode -> R/R 3 cyc, then NS G.
//  6 reset_n low mid EW_G (async, between edges) -> lamps R/R immediately, phase=5;
//    on release the test 1 sequence repeats.

Source files
------------

// File: rtl/tlc_param.sv
// tlc_param: two-road traffic light controller with configurable phase timing,
// demand-driven early green exit, an enable/hold input and emergency flashing yellow.
//   clock        in  rising-edge clock
//   reset_n      in  asynchronous active-low reset
//   enable       in  1 = run, 0 = freeze phase/counter (demands still latch)
//   flash_mode   in  1 = emergency flashing yellow (overrides enable)
//   req_ns       in  demand to serve North-South
//   req_ew       in  demand to serve East-West
//   North_South  out lamp code (red=1, green=2, yellow=4, off=0)
//   East_West    out lamp code
//   phase        out 0 NS_G, 1 NS_Y, 2 RED_A, 3 EW_G, 4 EW_Y, 5 RED_B, 6 FLASH
module tlc_param #(
  parameter int CNT_W      = 8,
  parameter int GREEN_NS   = 15,
  parameter int GREEN_EW   = 15,
  parameter int YELLOW     = 3,
  parameter int ALL_RED    = 3,
  parameter int MIN_GREEN  = 5,
  parameter int FLASH_HALF = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       flash_mode,
  input  logic       req_ns,
  input  logic       req_ew,
  output logic [3:0] North_South,
  output logic [3:0] East_West,
  output logic [2:0] phase
);
  typedef enum logic [2:0] {NS_G = 3'd0, NS_Y, RED_A, EW_G, EW_Y, RED_B, FLASH} state_t;
  localparam logic [3:0] OFF = 4'd0, RED = 4'd1, GRN = 4'd2, YEL = 4'd4;
  localparam logic [CNT_W-1:0] L_NS = CNT_W'(GREEN_NS - 1);
  localparam logic [CNT_W-1:0] L_EW = CNT_W'(GREEN_EW - 1);
  localparam logic [CNT_W-1:0] L_Y  = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] L_AR = CNT_W'(ALL_RED - 1);
  localparam logic [CNT_W-1:0] L_MG = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] L_FH = CNT_W'(FLASH_HALF - 1);
  state_t st, st_n, nxt;
  logic [CNT_W-1:0] cnt, cnt_n, lim;
  logic tog, tog_n, pend_ns, pend_ns_n, pend_ew, pend_ew_n, early;
  logic [3:0] ns_n, ew_n;
  assign phase = st;
  always_comb begin
    lim = st == NS_G ? L_NS : st == EW_G ? L_EW : (st == NS_Y || st == EW_Y) ? L_Y : L_AR;
    nxt = st == NS_G ? NS_Y : st == NS_Y ? RED_A : st == RED_A ? EW_G :
          st == EW_G ? EW_Y : st == EW_Y ? RED_B : NS_G;
    // a green may be cut short by the opposing demand once the minimum green has elapsed
    early = ((st == NS_G && (pend_ew || req_ew)) || (st == EW_G && (pend_ns || req_ns))) && cnt >= L_MG;
    st_n = st;
    cnt_n = cnt;
    tog_n = tog;
    if (flash_mode) begin
      if (st != FLASH) begin
        st_n = FLASH;
        cnt_n = '0;
        tog_n = 1'b0;
      end else if (cnt == L_FH) begin
        cnt_n = '0;
        tog_n = ~tog;
      end else cnt_n = cnt + 1'b1;
    end else if (st == FLASH || st == state_t'(3'd7)) begin
      st_n = RED_B;
      cnt_n = '0;
    end else if (enable) begin
      if (cnt == lim || early) begin
        st_n = nxt;
        cnt_n = '0;
      end else cnt_n = cnt + 1'b1;
    end
    // requests latch outside their own green and clear on entry to it
    pend_ns_n = (pend_ns || (req_ns && st != NS_G)) && !(st_n == NS_G && st != NS_G);
    pend_ew_n = (pend_ew || (req_ew && st != EW_G)) && !(st_n == EW_G && st != EW_G);
    // tog=0 is the yellow half of the flash cycle
    ns_n = st_n == NS_G ? GRN : st_n == NS_Y ? YEL : st_n == FLASH ? (tog_n ? OFF : YEL) : RED;
    ew_n = st_n == EW_G ? GRN : st_n == EW_Y ? YEL : st_n == FLASH ? (tog_n ? OFF : YEL) : RED;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      st <= RED_B;
      cnt <= '0;
      tog <= 1'b0;
      pend_ns <= 1'b0;
      pend_ew <= 1'b0;
      North_South <= RED;
      East_West <= RED;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      tog <= tog_n;
      pend_ns <= pend_ns_n;
      pend_ew <= pend_ew_n;
      North_South <= ns_n;
      East_West <= ew_n;
    end
endmodule
